seg7_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the board's eight common-anode 7-segment digits. Holds an 8-nibble display image and cycles one active-low anode at a time. Drives the shared active-low CA..CG and DP lines with the hex glyph of the selected nibble. Sits between the arithmetic datapath (adder sums, counters) and the AN/CA..CG/DP pins, replacing the static single-digit drive.

---
 rtl/seg7_scan_ctrl.sv | 85 ++++++++
 tb/tb_seg7_scan_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: eight-digit multiplexed 7-segment scanner with frame-synchronous image update.
// Define SEG7_LZ_BLANK_EN to enable leading-zero blanking.
module seg7_scan_ctrl #(
  parameter int DIV = 100000,
  parameter int DEAD = 100
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] VALUE,
  input  logic [7:0]  DIG_EN,
  input  logic [7:0]  DP_EN,
  input  logic        UPD_VALID,
  output logic        UPD_READY,
  output logic        FRAME_TICK,
  output logic [7:0]  AN,
  output logic        CA,
  output logic        CB,
  output logic        CC,
  output logic        CD,
  output logic        CE,
  output logic        CF,
  output logic        CG,
  output logic        DP
);
  localparam int CW = $clog2(DIV);
  localparam logic [16*7-1:0] GLYPH = {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
                                       7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [31:0] s_val, p_val;
  logic [7:0] s_en, s_dp, p_en, p_dp, lz_mask;
  logic pend, wrap, boundary, blank, lit;
  logic [3:0] nib;
  logic [6:0] seg;
  assign wrap = cnt == CW'(DIV - 1);
  assign boundary = wrap && idx == 3'd7;
  assign UPD_READY = ~pend;
  assign blank = cnt < CW'(DEAD);
  assign nib = s_val[{idx, 2'b00} +: 4];
  assign lit = s_en[idx] & lz_mask[idx];
  assign {CG, CF, CE, CD, CC, CB, CA} = seg;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      cnt <= '0;
      idx <= '0;
      pend <= 1'b0;
      {s_val, s_en, s_dp} <= '0;
      {p_val, p_en, p_dp} <= '0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      idx <= wrap ? idx + 3'd1 : idx;
      if (boundary && pend) begin
        {s_val, s_en, s_dp} <= {p_val, p_en, p_dp};
        pend <= 1'b0;
      end else if (UPD_VALID && !pend) begin
        {p_val, p_en, p_dp} <= {VALUE, DIG_EN, DP_EN};
        pend <= 1'b1;
      end
    end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      AN <= 8'hFF;
      seg <= 7'h7F;
      DP <= 1'b1;
      FRAME_TICK <= 1'b0;
    end else begin
      AN <= (blank || !lit) ? 8'hFF : ~(8'h01 << idx);
      seg <= (blank || !lit) ? 7'h7F : ~GLYPH[nib*7 +: 7];
      DP <= blank || !s_dp[idx];
      FRAME_TICK <= boundary;
    end
`ifdef SEG7_LZ_BLANK_EN
  logic [7:0] lz_next;
  // Mask follows the image being committed, so it changes only with the shadow.
  always_comb begin
    lz_next = 8'h01;
    for (int i = 1; i < 8; i++) lz_next[i] = |(p_val >> (4 * i));
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) lz_mask <= 8'h01;
    else if (boundary && pend) lz_mask <= lz_next;
`else
  assign lz_mask = 8'hFF;
`endif
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: randomized scoreboard bench for seg7_scan_ctrl with a frame-level reference model.
module tb_seg7_scan_ctrl;
  localparam int DIV = 8, DEAD = 2, FRAME = 8 * DIV;
  localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic CLK = 1'b0, RST = 1'b1, UPD_VALID = 1'b0;
  logic [31:0] VALUE = '0;
  logic [7:0] DIG_EN = '0, DP_EN = '0, AN;
  logic UPD_READY, FRAME_TICK, CA, CB, CC, CD, CE, CF, CG, DP;
  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic dp, tick, rdy;
  } obs_t;
  obs_t q[$];
  obs_t got, want;
  int checks = 0, fails = 0, n = 0;
  logic [31:0] s_val = '0, p_val = '0;
  logic [7:0] s_en = '0, s_dp = '0, p_en = '0, p_dp = '0;
  bit pend = 0;

  seg7_scan_ctrl #(.DIV(DIV), .DEAD(DEAD)) dut (
    .CLK(CLK), .RST(RST), .VALUE(VALUE), .DIG_EN(DIG_EN), .DP_EN(DP_EN),
    .UPD_VALID(UPD_VALID), .UPD_READY(UPD_READY), .FRAME_TICK(FRAME_TICK), .AN(AN),
    .CA(CA), .CB(CB), .CC(CC), .CD(CD), .CE(CE), .CF(CF), .CG(CG), .DP(DP)
  );

  always #5 CLK = ~CLK;

  function automatic obs_t observe();
    return {AN, CG, CF, CE, CD, CC, CB, CA, DP, FRAME_TICK, UPD_READY};
  endfunction

  function automatic bit shown(int dig);
`ifdef SEG7_LZ_BLANK_EN
    return dig == 0 || (s_val >> (4 * dig)) != 0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    n = 0;
    pend = 0;
    {s_val, s_en, s_dp, p_val, p_en, p_dp} = '0;
  endtask

  task automatic step(input bit v, input logic [31:0] val, input logic [7:0] en, input logic [7:0] dp);
    obs_t e;
    int pos, dig;
    bit lit, edge_of_frame;
    @(negedge CLK);
    UPD_VALID = v;
    VALUE = val;
    DIG_EN = en;
    DP_EN = dp;
    pos = n % DIV;
    dig = (n / DIV) % 8;
    edge_of_frame = (n % FRAME) == FRAME - 1;
    lit = s_en[dig] && shown(dig);
    e.an = (pos < DEAD || !lit) ? 8'hFF : ~(8'h01 << dig);
    e.seg = (pos < DEAD || !lit) ? 7'h7F : ~GLYPH[s_val[4*dig +: 4]];
    e.dp = (pos < DEAD) ? 1'b1 : ~s_dp[dig];
    e.tick = edge_of_frame;
    if (pend && edge_of_frame) begin
      {s_val, s_en, s_dp} = {p_val, p_en, p_dp};
      pend = 0;
    end else if (v && !pend) begin
      {p_val, p_en, p_dp} = {val, en, dp};
      pend = 1;
    end
    e.rdy = !pend;
    n++;
    q.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, $urandom, 8'($urandom), 8'($urandom));
  endtask

  task automatic run_to(int pos);
    while (n % FRAME != pos) idle();
  endtask

  task automatic frames(int k);
    repeat (k * FRAME) idle();
  endtask

  always @(posedge CLK) begin
    #1;
    if (!RST && q.size() > 0) begin
      want = q.pop_front();
      got = observe();
      checks++;
      if (got !== want) begin
        fails++;
        $display("FAIL scan t=%0t got an=%h seg=%h dp=%b tick=%b rdy=%b expected an=%h seg=%h dp=%b tick=%b rdy=%b",
                 $time, got.an, got.seg, got.dp, got.tick, got.rdy, want.an, want.seg, want.dp, want.tick, want.rdy);
      end
    end
  end

  initial begin
    repeat (3) @(negedge CLK);
    @(posedge CLK);
    #2 RST = 1'b0;
    repeat (10) idle();
    step(1'b1, 32'h7654_3210, 8'hFF, 8'h01);
    frames(3);
    run_to(19);
    step(1'b1, 32'hFFFF_FFFF, 8'hFF, 8'h00);
    repeat (5) step(1'b1, $urandom, 8'($urandom), 8'($urandom));
    frames(2);
    run_to(FRAME - 1);
    step(1'b1, 32'h0000_00A5, 8'hFF, 8'hF0);
    frames(2);
    step(1'b1, 32'h7654_3210, 8'hFE, 8'h01);
    frames(2);
    step(1'b1, 32'h0000_0050, 8'hFF, 8'h00);
    frames(2);
    run_to(12);
    idle();
    @(posedge CLK);
    #2 RST = 1'b1;
    #1 got = observe();
    checks++;
    if (got !== {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL async_reset got an=%h seg=%h dp=%b tick=%b rdy=%b expected an=ff seg=7f dp=1 tick=0 rdy=1",
               got.an, got.seg, got.dp, got.tick, got.rdy);
    end
    q.delete();
    model_reset();
    repeat (3) @(posedge CLK);
    #2 RST = 1'b0;
    repeat (16) idle();
    repeat (900) begin
      if ($urandom_range(3) == 0) step(1'b1, $urandom, 8'($urandom), 8'($urandom));
      else idle();
    end
    @(posedge CLK);
    #2;
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
